// File: rtl/i2c_slave_responder_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE,
    WAIT_STOP
  } i2c_slave_state_t;

  localparam logic       I2C_RW_READ   = 1'b1;
  localparam int         I2C_BYTE_BITS = 8;
  localparam logic [2:0] I2C_LAST_BIT  = 3'(I2C_BYTE_BITS - 1);

  // Addressed phases of a transfer.
  function automatic logic state_is_busy(input i2c_slave_state_t s);
    case (s)
      ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_slave_responder_bus_sync.sv
// SCL/SDA synchronizers plus registered edge and START/STOP pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Idle bus level is high, so everything presets to 1 to avoid false events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
      o_scl_rise <= 1'b0;
      o_scl_fall <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
      o_sda      <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
      o_scl_rise <= w_scl & ~r_scl_hist;
      o_scl_fall <= ~w_scl & r_scl_hist;
      o_start    <= w_scl & r_scl_hist & r_sda_hist & ~w_sda;
      o_stop     <= w_scl & r_scl_hist & ~r_sda_hist & w_sda;
      o_sda      <= w_sda;
    end
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: acks SLAVE_ADDR, streams written bytes to a sink and read bytes from a source.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  input  logic       wr_full_i,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_sda;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  i2c_slave_state_t r_state;
  logic [6:0]       r_shift;
  logic [7:0]       r_tx;
  logic [2:0]       r_bit_cnt;
  logic             r_rw;
  logic             r_ack_drv;  // ACK slot currently being driven
  logic             r_ack_ok;
  logic             r_first;    // next fall puts the MSB of a fresh read byte on the bus

  assign busy_o = state_is_busy(r_state);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_tx       <= '0;
      r_bit_cnt  <= '0;
      r_rw       <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_first    <= 1'b0;
      sda_oe_o   <= 1'b0;
      wr_data_o  <= '0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= '0;
        r_ack_drv <= 1'b0;
        r_first   <= 1'b0;
        sda_oe_o  <= 1'b0;
        start_o   <= 1'b1;
      end else if (w_stop) begin
        r_state   <= IDLE;
        r_ack_drv <= 1'b0;
        sda_oe_o  <= 1'b0;
        stop_o    <= 1'b1;
      end else begin
        case (r_state)
          ADDR: if (w_scl_rise) begin
            r_shift   <= {r_shift[5:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == I2C_LAST_BIT) begin
              r_rw    <= w_sda;
              r_state <= (r_shift == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
            end
          end
          ADDR_ACK: begin
            if (w_scl_rise && r_rw == I2C_RW_READ) rd_req_o <= 1'b1;
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                sda_oe_o  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                if (r_rw == I2C_RW_READ) begin
                  sda_oe_o <= ~r_tx[7];
                  r_first  <= 1'b0;
                  r_state  <= RD_DATA;
                end else begin
                  sda_oe_o <= 1'b0;
                  r_state  <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: if (w_scl_rise) begin
            r_shift   <= {r_shift[5:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == I2C_LAST_BIT) begin
              r_state    <= WR_ACK;
              wr_data_o  <= {r_shift, w_sda};
              wr_valid_o <= ~wr_full_i;
              r_ack_ok   <= ~wr_full_i;
            end
          end
          WR_ACK: if (w_scl_fall) begin
            if (!r_ack_drv) begin
              sda_oe_o  <= r_ack_ok;
              r_ack_drv <= 1'b1;
            end else begin
              sda_oe_o  <= 1'b0;
              r_ack_drv <= 1'b0;
              r_state   <= WR_DATA;
            end
          end
          RD_DATA: if (w_scl_fall) begin
            if (r_first) begin
              sda_oe_o <= ~r_tx[7];
              r_first  <= 1'b0;
            end else if (r_bit_cnt == I2C_LAST_BIT) begin
              sda_oe_o  <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= RD_ACK;
            end else begin
              r_tx      <= {r_tx[6:0], 1'b0};
              sda_oe_o  <= ~r_tx[6];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          RD_ACK: if (w_scl_rise) begin
            if (!w_sda) begin
              rd_req_o <= 1'b1;
              r_first  <= 1'b1;
              r_state  <= RD_DATA;
            end else begin
              r_state  <= WAIT_STOP;
            end
          end
          default: sda_oe_o <= 1'b0;
        endcase
      end
      // Source byte is taken in the cycle the request strobe is visible.
      if (rd_req_o) r_tx <= rd_data_i;
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master drives the responder over an open-drain SDA model.
module tb_i2c_slave_responder;
  import i2c_slave_pkg::*;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       bus_sda;
  logic       sda_oe_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       wr_full = 1'b0;
  logic       rd_req_o;
  logic [7:0] rd_data;
  logic       start_o;
  logic       stop_o;
  logic       busy_o;

  logic [7:0] rd_src [16];
  logic [3:0] rd_idx = 4'd0;

  logic [7:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int n_wr = 0, n_rd = 0, n_start = 0, n_stop = 0, n_oe = 0;

  assign bus_sda = m_sda & ~sda_oe_o;
  assign rd_data = rd_src[rd_idx];

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (m_scl),
    .sda_i      (bus_sda),
    .sda_oe_o   (sda_oe_o),
    .wr_data_o  (wr_data_o),
    .wr_valid_o (wr_valid_o),
    .wr_full_i  (wr_full),
    .rd_req_o   (rd_req_o),
    .rd_data_i  (rd_data),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source advances after each request strobe.
  always @(posedge clk) if (rd_req_o) rd_idx <= rd_idx + 4'd1;

  // Pulse counters and write-data scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid_o) begin
        n_wr++;
        if (exp_q.size() == 0) chk("wr_unexpected_strobe", 32'(wr_valid_o), 32'd0);
        else                   chk("wr_data", 32'(wr_data_o), 32'(exp_q.pop_front()));
      end
      if (rd_req_o) n_rd++;
      if (start_o)  n_start++;
      if (stop_o)   n_stop++;
      if (sda_oe_o) n_oe++;
    end
  end

  task automatic m_wait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start;
    m_sda = 1'b1; m_wait;
    m_scl = 1'b1; m_wait;
    m_sda = 1'b0; m_wait;
    m_scl = 1'b0; m_wait;
  endtask

  task automatic m_stop;
    m_sda = 1'b0; m_wait;
    m_scl = 1'b1; m_wait;
    m_sda = 1'b1; m_wait;
  endtask

  task automatic m_wbit(input logic b);
    m_sda = b;    m_wait;
    m_scl = 1'b1; m_wait;
    m_scl = 1'b0; m_wait;
  endtask

  task automatic m_rbit(output logic b);
    m_sda = 1'b1; m_wait;
    m_scl = 1'b1;
    repeat (Q/2) @(negedge clk);
    b = bus_sda;
    repeat (Q - Q/2) @(negedge clk);
    m_scl = 1'b0; m_wait;
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(b);
    ack = ~b;
  endtask

  task automatic m_rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(~ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int b_wr, b_rd, b_start, b_stop, b_oe;
    logic [7:0] v77;

    for (int i = 0; i < 16; i++) rd_src[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_wr_data", 32'(wr_data_o), 32'd0);
    chk("rst_rd_req", 32'(rd_req_o), 32'd0);
    chk("rst_start_stop", 32'({start_o, stop_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    m_wait;

    // Write 0x44: 0xA5, 0x3C, STOP
    b_wr = n_wr; b_start = n_start; b_stop = n_stop;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    m_start;
    m_wbyte(8'h44, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
    chk("wr_busy_mid", 32'(busy_o), 32'd1);
    m_wbyte(8'hA5, ack); chk("wr_b0_ack", 32'(ack), 32'd1);
    m_wbyte(8'h3C, ack); chk("wr_b1_ack", 32'(ack), 32'd1);
    m_stop;
    chk("wr_count", 32'(n_wr - b_wr), 32'd2);
    chk("wr_start_count", 32'(n_start - b_start), 32'd1);
    chk("wr_stop_count", 32'(n_stop - b_stop), 32'd1);
    chk("wr_busy_after_stop", 32'(busy_o), 32'd0);
    chk("wr_state_after_stop", 32'(dut.r_state), 32'(IDLE));

    // Foreign address 0x46 is ignored
    b_wr = n_wr; b_rd = n_rd; b_oe = n_oe;
    m_start;
    m_wbyte(8'h46, ack); chk("ign_addr_nack", 32'(ack), 32'd0);
    m_wbyte(8'h12, ack); chk("ign_data_nack", 32'(ack), 32'd0);
    chk("ign_state", 32'(dut.r_state), 32'(IGNORE));
    chk("ign_busy", 32'(busy_o), 32'd0);
    m_stop;
    chk("ign_oe_cycles", 32'(n_oe - b_oe), 32'd0);
    chk("ign_wr_count", 32'(n_wr - b_wr), 32'd0);
    chk("ign_rd_count", 32'(n_rd - b_rd), 32'd0);
    chk("ign_state_after_stop", 32'(dut.r_state), 32'(IDLE));

    // Read 0x45: 0xC3 (ACK), 0x81 (NACK)
    b_rd = n_rd;
    rd_src[rd_idx] = 8'hC3;
    rd_src[4'(rd_idx + 4'd1)] = 8'h81;
    m_start;
    m_wbyte(8'h45, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
    m_rbyte(d, 1'b1);    chk("rd_byte0", 32'(d), 32'hC3);
    m_rbyte(d, 1'b0);    chk("rd_byte1", 32'(d), 32'h81);
    chk("rd_state_nack", 32'(dut.r_state), 32'(WAIT_STOP));
    chk("rd_busy_nack", 32'(busy_o), 32'd0);
    chk("rd_req_count", 32'(n_rd - b_rd), 32'd2);
    m_stop;

    // Sink full: data byte NACKed, no strobe
    b_wr = n_wr;
    wr_full = 1'b1;
    m_start;
    m_wbyte(8'h44, ack); chk("full_addr_ack", 32'(ack), 32'd1);
    m_wbyte(8'h10, ack); chk("full_data_nack", 32'(ack), 32'd0);
    m_stop;
    wr_full = 1'b0;
    chk("full_wr_count", 32'(n_wr - b_wr), 32'd0);

    // Write 0x55, repeated START, read 0x45
    b_wr = n_wr; b_rd = n_rd; b_start = n_start;
    rd_src[rd_idx] = 8'h9A;
    exp_q.push_back(8'h55);
    m_start;
    m_wbyte(8'h44, ack); chk("rs_waddr_ack", 32'(ack), 32'd1);
    m_wbyte(8'h55, ack); chk("rs_wdata_ack", 32'(ack), 32'd1);
    m_start;
    chk("rs_state_addr", 32'(dut.r_state), 32'(ADDR));
    m_wbyte(8'h45, ack); chk("rs_raddr_ack", 32'(ack), 32'd1);
    m_rbyte(d, 1'b0);    chk("rs_rdata", 32'(d), 32'h9A);
    m_stop;
    chk("rs_start_count", 32'(n_start - b_start), 32'd2);
    chk("rs_wr_count", 32'(n_wr - b_wr), 32'd1);
    chk("rs_rd_count", 32'(n_rd - b_rd), 32'd1);

    // Reset while driving a write ACK, then a clean transfer
    b_wr = n_wr;
    v77 = 8'h77;
    exp_q.push_back(8'h77);
    m_start;
    m_wbyte(8'h44, ack); chk("rr_addr_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) m_wbit(v77[i]);
    chk("rr_ack_driven", 32'(sda_oe_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_oe_released", 32'(sda_oe_o), 32'd0);
    chk("rr_state_idle", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    m_wait;
    exp_q.push_back(8'h66);
    m_start;
    m_wbyte(8'h44, ack); chk("rr2_addr_ack", 32'(ack), 32'd1);
    m_wbyte(8'h66, ack); chk("rr2_data_ack", 32'(ack), 32'd1);
    m_stop;
    chk("rr_wr_count", 32'(n_wr - b_wr), 32'd2);
    chk("rr_busy_end", 32'(busy_o), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Synthesizable I2C target (slave) for the far end of the i2cmb master's bus. It samples SCL/SDA and detects START/repeated-START/STOP. It acknowledges a configured 7-bit address, delivers written bytes to a local sink, and fetches read bytes from a local source. It sits on the DUT bus beside the I2C agent, giving a hardware responder for master-side regression; it does no clock stretching.

Parameters:
SLAVE_ADDR, 7'h22, 7-bit address the block responds to
SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (minimum 2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
scl_i  input  1  raw SCL from bus
sda_i  input  1  raw SDA from bus
sda_oe_o  output  1  1 = pull SDA low (open-drain); 0 = release
wr_data_o  output  8  byte received in a write transfer
wr_valid_o  output  1  one-cycle strobe; wr_data_o valid
wr_full_i  input  1  sink cannot accept; the data byte is NACKed
rd_req_o  output  1  one-cycle strobe requesting next read byte
rd_data_i  input  8  read byte; sampled in the cycle rd_req_o=1
start_o  output  1  one-cycle pulse on START or repeated START
stop_o  output  1  one-cycle pulse on STOP
busy_o  output  1  1 while addressed (from ADDR_ACK until STOP, START or master NACK)

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state IDLE; all outputs 0; synchronizers preset to 1; shift registers and bit counter 0. Reset mid-transfer drops the transfer and releases SDA immediately.
- Input path: SYNC_STAGES-flop sync, then one history flop. Events use synced values: scl_rise, scl_fall, start (SDA 1->0 while SCL=1), stop (SDA 0->1 while SCL=1).
- START/STOP have priority over bit events in the same cycle. START from any state: bit counter=0, SDA released, go to ADDR, pulse start_o. STOP from any state: release SDA, go to IDLE, pulse stop_o.
- Bits are sampled on scl_rise, MSB first. SDA is changed only in the cycle after scl_fall detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th scl_rise: if addr[7:1]==SLAVE_ADDR, go to ADDR_ACK; else go to IGNORE.
  - ADDR_ACK: at the next scl_fall, sda_oe_o=1. At the following scl_fall, release. R/W=0 -> WR_DATA. R/W=1 -> RD_DATA, and SDA is instead driven with bit 7 of the read byte.
  - Read fetch: the first rd_req_o pulses on the scl_rise of the address ACK bit, and rd_data_i is captured that cycle.
  - WR_DATA: shift 8 bits. On the 8th scl_rise, go to WR_ACK. In the next cycle, if wr_full_i=0, pulse wr_valid_o with the byte and ACK; else no strobe and NACK (SDA left released).
  - WR_ACK: drive from the next scl_fall to the one after it, then return to WR_DATA.
  - RD_DATA: on each scl_fall, drive sda_oe_o = ~bit (the MSB is driven at the ADDR_ACK exit). After the 8th bit's scl_fall, release and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise. SDA=0 (ACK): pulse rd_req_o, capture rd_data_i, go to RD_DATA. SDA=1 (NACK): go to WAIT_STOP.
  - IGNORE / WAIT_STOP: SDA released; leave only on START or STOP.
- Bit counter is 3 bits and wraps 7->0 at the byte boundary.
- Driving a 1 means release, so lost arbitration is not detected.
- busy_o=1 in ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.

Decomposition:
- Shared package i2c_slave_pkg holds:
  - state enum i2c_slave_state_t {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE, WAIT_STOP}
  - constants I2C_RW_READ=1'b1, I2C_BYTE_BITS=8
- Sub-module i2c_bus_sync: synchronizers, edge detection, start/stop detection. Outputs are registered single-cycle pulses.

Test Plan:
- Write 0x44, data 0xA5, 0x3C, STOP -> ACKs on address and both bytes; wr_valid_o twice with 0xA5 then 0x3C; stop_o once; busy_o low after STOP.
- Address 0x46 (7'h23) -> SDA never driven; no wr_valid_o or rd_req_o; state IGNORE until STOP.
- Read 0x45, rd_data_i=0xC3 then 0x81, master ACK then NACK -> bus bits 11000011 then 10000001; two rd_req_o pulses; WAIT_STOP after NACK.
- Write 0x44, byte 0x10 with wr_full_i=1 -> 9th bit high (NACK); no wr_valid_o.
- Write 0x44, byte 0x55, repeated START, read 0x45 -> start_o twice; wr_valid_o(0x55); first read byte taken from rd_data_i.
- rst_i asserted while driving ACK mid-write -> sda_oe_o=0 the next cycle; a following START/0x44 transfer completes normally.
